// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// Purpose
//   Store side of the load/store path. Takes one store request at a time
//   (word, halfword, or optionally byte) and writes it into a 32-bit
//   word-organised synchronous data RAM. Word stores are written directly.
//   Sub-word stores read the target word, merge the new lane(s) in, and write
//   the whole word back.
//
// Configuration
//   STORE_BYTE_EN  defined   : byte stores (req_sb) are supported.
//                  undefined : byte stores are rejected with done+err and no
//                              RAM access; the merge path handles halfwords only.
//
// Parameters
//   ADDR_W      word-address width of the data RAM. Byte address bits
//               [ADDR_W+1:2] are used; higher address bits are dropped.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req_valid/ready     store request handshake (see below)
//   req_addr[31:0]      byte address
//   req_data[31:0]      store data (SH uses [15:0], SB uses [7:0])
//   req_sh, req_sb      halfword / byte store; both low = word store
//   mem_addr            RAM word address, held from READ through WRITE
//   mem_rd_en           RAM read strobe; mem_rdata is valid the next cycle
//   mem_rdata[31:0]     RAM read data
//   mem_wr_en           RAM full-word write strobe
//   mem_wdata[31:0]     RAM write data
//   done                one-cycle completion pulse
//   err                 with done: request rejected, nothing written
//   dbg_state[2:0]      current FSM state (IDLE=0 READ=1 MERGE=2 WRITE=3 ERR=4)
//
// Handshake
//   A request transfers on a rising edge where req_valid && req_ready.
//   req_ready is high only in IDLE and depends on nothing but the state.
//   Address, data and store type are captured on that edge. The request
//   inputs are ignored from then on until the unit is back in IDLE. The
//   request finishes with exactly one done pulse.
// -----------------------------------------------------------------------------
module store_merge_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic              req_sh,
    input  logic              req_sb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    // Sub-word data replicated across every lane it could land in, plus a
    // byte-enable mask that selects the lanes actually being written.
    logic [31:0]       data_q,  data_d;
    logic [3:0]        be_q,    be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              is_word;
    logic              is_half;
    logic              reject;
    logic [31:0]       merged;

    // Address bits above the RAM range are dropped (addresses wrap).
    logic              unused_addr_hi;
    assign unused_addr_hi = &{1'b0, req_addr[31:ADDR_W+2]};

    // Request classification, evaluated on the request inputs in IDLE.
    always_comb begin
        is_word = !req_sh && !req_sb;
        is_half =  req_sh && !req_sb;
        reject  = 1'b0;
        if (req_sh && req_sb) begin
            reject = 1'b1;
        end else if (is_word && (req_addr[1:0] != 2'b00)) begin
            reject = 1'b1;
        end else if (is_half && req_addr[0]) begin
            reject = 1'b1;
        end
`ifndef STORE_BYTE_EN
        if (!req_sh && req_sb) begin
            reject = 1'b1;
        end
`endif
    end

    // Lane merge: enabled bytes come from the store data, the rest keep the
    // RAM contents that were read in the previous cycle.
    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = data_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (reject) begin
                        // mem_addr stays untouched for rejected requests.
                        state_d = S_ERR;
                    end else begin
                        addr_d = req_addr[ADDR_W+1:2];
                        if (is_word) begin
                            wdata_d = req_data;
                            state_d = S_WRITE;
                        end else begin
`ifdef STORE_BYTE_EN
                            if (is_half) begin
                                data_d = {2{req_data[15:0]}};
                                be_d   = req_addr[1] ? 4'b1100 : 4'b0011;
                            end else begin
                                data_d = {4{req_data[7:0]}};
                                be_d   = 4'b0001 << req_addr[1:0];
                            end
`else
                            data_d = {2{req_data[15:0]}};
                            be_d   = req_addr[1] ? 4'b1100 : 4'b0011;
`endif
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                state_d = S_MERGE;
            end
            S_MERGE: begin
                wdata_d = merged;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // All strobes decode straight from the state, so a reset drops them
    // immediately and rd/wr can never overlap.
    assign req_ready = (state_q == S_IDLE);
    assign mem_rd_en = (state_q == S_READ);
    assign mem_wr_en = (state_q == S_WRITE);
    assign done      = (state_q == S_WRITE) || (state_q == S_ERR);
    assign err       = (state_q == S_ERR);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef STORE_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [31:0]       req_data;
  logic              req_sh;
  logic              req_sb;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  store_merge_unit #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_sh    (req_sh),
    .req_sb    (req_sb),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Synchronous RAM attached to the DUT.
  logic [31:0] ram [DEPTH];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
  end

  // ---------------------------------------------------------------- reference
  // Architectural memory image: updated only when a store is reported done.
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic              err;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    int                lat;
    int                nrd;
    int                acc;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int neg_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Store semantics from the rules: alignment, little-endian lanes, wrap.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                 input logic sh, input logic sb);
    exp_t e;
    logic [31:0] w;
    int off;
    e.waddr = a[ADDR_W+1:2];
    w       = ref_mem[e.waddr];
    e.err   = 1'b0;
    e.lat   = 1;
    e.nrd   = 0;
    e.acc   = 0;
    if (sh && sb) begin
      e.err = 1'b1;
    end else if (!sh && !sb) begin
      if (a[1:0] != 2'b00) e.err = 1'b1;
      else w = d;
    end else if (sh) begin
      if (a[0]) e.err = 1'b1;
      else begin
        off = a[1] ? 16 : 0;
        w[off +: 16] = d[15:0];
        e.lat = 3;
        e.nrd = 1;
      end
    end else begin
      if (!BYTE_EN) e.err = 1'b1;
      else begin
        off = 8 * int'(a[1:0]);
        w[off +: 8] = d[7:0];
        e.lat = 3;
        e.nrd = 1;
      end
    end
    e.wdata = w;
    return e;
  endfunction

  // ---------------------------------------------------------------- monitor
  int rd_seen = 0;
  int wr_seen = 0;

  always @(negedge clk) begin
    exp_t h;
    if (!rst_n) begin
      rd_seen = 0;
      wr_seen = 0;
    end else begin
      neg_cyc++;
      chk("req_ready", 32'(req_ready), 32'(exp_q.size() == 0));
      if (mem_rd_en || mem_wr_en)
        chk("rd_wr_exclusive", 32'(mem_rd_en & mem_wr_en), 32'd0);
      if (exp_q.size() == 0) begin
        chk("idle_strobes", 32'({mem_rd_en, mem_wr_en, done, err}), 32'd0);
      end else begin
        h = exp_q[0];
        if (mem_rd_en) begin
          rd_seen++;
          chk("rd_addr", 32'(mem_addr), 32'(h.waddr));
        end
        if (mem_wr_en) begin
          wr_seen++;
          chk("wr_addr", 32'(mem_addr), 32'(h.waddr));
          chk("wr_data", mem_wdata, h.wdata);
        end
        if (done) begin
          chk("err", 32'(err), 32'(h.err));
          chk("latency", neg_cyc - h.acc, h.lat);
          chk("rd_count", rd_seen, h.nrd);
          chk("wr_count", wr_seen, h.err ? 0 : 1);
          if (!h.err) ref_mem[h.waddr] = h.wdata;
          void'(exp_q.pop_front());
          rd_seen = 0;
          wr_seen = 0;
        end else if (neg_cyc - h.acc > 8) begin
          chk("done_timeout", 32'd0, 32'd1);
          void'(exp_q.pop_front());
          rd_seen = 0;
          wr_seen = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  int last_acc = 0;

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic sh, input logic sb);
    int waited;
    exp_t e;
    waited    = 0;
    req_addr  = a;
    req_data  = d;
    req_sh    = sh;
    req_sb    = sb;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = model(a, d, sh, sb);
    e.acc = neg_cyc;
    last_acc = neg_cyc;
    exp_q.push_back(e);
    #1;
  endtask

  // Deassert valid and scramble the other inputs; they must be ignored.
  task automatic idle(input int n);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_sh    = 1'($urandom_range(0, 1));
    req_sb    = 1'($urandom_range(0, 1));
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [31:0] v);
    ram[a] <= v;
    ref_mem[a] = v;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_strobes"}, 32'({mem_rd_en, mem_wr_en, done, err}), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, a4;
    logic [31:0] v, a, d;
    int kind, gap;
    logic sh, sb;

    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_sh    = 1'b0;
    req_sb    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      poke(i, v);
    end
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Word store.
    issue(32'h8, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(2);
    // Halfword RMW into the upper lane.
    poke(1, 32'h11223344);
    issue(32'h6, 32'h0000ABCD, 1'b1, 1'b0);
    idle(1);
    // Misaligned halfword.
    issue(32'h5, 32'h00001234, 1'b1, 1'b0);
    idle(1);
    // Byte store (merge or reject depending on build).
    poke(0, 32'h11223344);
    issue(32'h1, 32'h00000077, 1'b0, 1'b1);
    idle(1);
    // Both type bits set, and misaligned word.
    issue(32'h10, 32'h0BADF00D, 1'b1, 1'b1);
    issue(32'h12, 32'h0BADF00D, 1'b0, 1'b0);
    idle(4);

    // Reset while a halfword store sits in MERGE.
    issue(32'h14, 32'h00005555, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(6);

    // Back-to-back with valid held high: SW, SH, SH, SW.
    issue(32'h20, $urandom, 1'b0, 1'b0);
    a1 = last_acc;
    issue(32'h22, $urandom, 1'b1, 1'b0);
    a2 = last_acc;
    issue(32'h20, $urandom, 1'b1, 1'b0);
    a3 = last_acc;
    issue(32'h24, $urandom, 1'b0, 1'b0);
    a4 = last_acc;
    chk("b2b_sw_gap", a2 - a1, 2);
    chk("b2b_sh_gap", a3 - a2, 4);
    chk("b2b_sh_gap2", a4 - a3, 4);
    idle(3);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      sh = (kind >= 4 && kind <= 6) || kind == 9;
      sb = (kind >= 7);
      a  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 31)) : $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (!sh && !sb) a[1:0] = 2'b00;
        else if (sh && !sb) a[0] = 1'b0;
      end
      d = $urandom;
      issue(a, d, sh, sb);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end

    idle(2);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
